// File: rtl/vga_pkg.sv
// vga_pkg -- shared definitions for the VGA pattern generator.
// Holds the default 640x480 timing constants, the default colour depth,
// the checkerboard cell size, the scroll-bar width and the pattern-mode
// encoding used by vga_timing and vga_pattern_gen.
package vga_pkg;

  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_COLOR_W   = 8;
  localparam int DEF_CELL_LOG2 = 6;

  // Width in pixels of the moving bar drawn in SCROLL mode.
  localparam int SCROLL_W = 16;

  // Pattern select encoding; codes 5..7 are unnamed and give mid-grey.
  typedef enum logic [2:0] {
    MODE_BLACK   = 3'd0,
    MODE_WINDOW  = 3'd1,
    MODE_BARS    = 3'd2,
    MODE_CHECKER = 3'd3,
    MODE_SCROLL  = 3'd4
  } mode_e;

endpackage

// File: rtl/vga_timing.sv
// vga_timing -- raster counters and sync decode.
// Ports:
//   clk, rst_n        pixel clock, already-synchronised active-low reset
//   hcount, vcount    undelayed column / line counters
//   active_raw        undelayed visible-region flag (same cycle as counters)
//   frame_origin      counters are at (0,0) this cycle
//   frame_last        counters are at the last pixel of the frame
//   hsync, vsync      registered sync strobes (one cycle behind counters)
//   active_video      registered visible-region flag
//   frame_start       registered one-cycle pulse for pixel (0,0)
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          active_raw,
  output logic          frame_origin,
  output logic          frame_last,
  output logic          hsync,
  output logic          vsync,
  output logic          active_video,
  output logic          frame_start
);

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          active_q, active_d;
  logic          frame_start_q, frame_start_d;
  logic          h_last_s, v_last_s;
  int            h_i, v_i;

  // Counter advance and sync/active decode from the current counter values.
  always_comb begin
    h_i      = int'(h_q);
    v_i      = int'(v_q);
    h_last_s = (h_i == H_TOTAL - 1);
    v_last_s = (v_i == V_TOTAL - 1);

    if (h_last_s) begin
      h_d = '0;
    end else begin
      h_d = h_q + HW'(1);
    end

    // Lines only advance on the horizontal wrap.
    if (h_last_s) begin
      if (v_last_s) begin
        v_d = '0;
      end else begin
        v_d = v_q + VW'(1);
      end
    end else begin
      v_d = v_q;
    end

    active_d      = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
    hsync_d       = ((h_i >= HS_START) && (h_i < HS_END)) ? HS_POL : ~HS_POL;
    vsync_d       = ((v_i >= VS_START) && (v_i < VS_END)) ? VS_POL : ~VS_POL;
    frame_start_d = (h_q == '0) && (v_q == '0);
  end

  // Counter and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount       = h_q;
  assign vcount       = v_q;
  assign active_raw   = active_d;
  assign frame_origin = frame_start_d;
  assign frame_last   = h_last_s && v_last_s;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign active_video = active_q;
  assign frame_start  = frame_start_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen -- VGA timing plus test-pattern generator.
// Ports:
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   mode[2:0]             pattern select, taken once per frame at (0,0)
//   vga_clk               copy of clk for the DAC
//   hsync, vsync          registered sync strobes
//   active_video          registered visible-region flag
//   hcount, vcount        undelayed raster position
//   red, green, blue      registered pixel colour
//   frame_start           registered one-cycle pulse for pixel (0,0)
// Registered outputs lag the hcount/vcount value that produced them by one clk.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int COLOR_W   = DEF_COLOR_W,
  parameter int CELL_LOG2 = DEF_CELL_LOG2,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         mode,
  output logic               vga_clk,
  output logic               hsync,
  output logic               vsync,
  output logic               active_video,
  output logic [HW-1:0]      hcount,
  output logic [VW-1:0]      vcount,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               frame_start
);

  localparam logic [COLOR_W-1:0] FULL = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] GREY = {1'b1, {(COLOR_W-1){1'b0}}};
  localparam logic [COLOR_W-1:0] ZERO = {COLOR_W{1'b0}};

  logic [1:0]         rst_sync_q, rst_sync_d;
  logic               rst_int_n;
  logic               active_raw, frame_origin, frame_last;
  logic [2:0]         mode_q, mode_d, mode_sel;
  logic [HW-1:0]      offset_q, offset_d;
  logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [2:0]         bar_s;
  logic               win_on, chk_on, scr_on;
  int                 h_i, off_i;

  assign vga_clk = clk;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Two-flop reset-release synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_int_n = rst_sync_q[1];

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HS_POL   (HS_POL),   .VS_POL (VS_POL)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_int_n),
    .hcount       (hcount),
    .vcount       (vcount),
    .active_raw   (active_raw),
    .frame_origin (frame_origin),
    .frame_last   (frame_last),
    .hsync        (hsync),
    .vsync        (vsync),
    .active_video (active_video),
    .frame_start  (frame_start)
  );

  // Frame-latched mode, scroll offset and the pixel colour for this position.
  always_comb begin
    // The incoming mode is used directly at (0,0) so the whole frame,
    // including its first pixel, is drawn with one consistent mode.
    mode_sel = frame_origin ? mode : mode_q;
    mode_d   = mode_sel;

    // Advance the scroll offset as the last pixel of a frame goes by, so
    // every pixel of a frame sees the same offset.
    if (frame_last) begin
      if (int'(offset_q) == H_ACTIVE - 1) begin
        offset_d = '0;
      end else begin
        offset_d = offset_q + HW'(1);
      end
    end else begin
      offset_d = offset_q;
    end

    h_i    = int'(hcount);
    off_i  = int'(offset_q);
    bar_s  = 3'((h_i * 8) / H_ACTIVE);
    win_on = (h_i > H_ACTIVE / 8) && (h_i < (7 * H_ACTIVE) / 8);
    chk_on = hcount[CELL_LOG2] ^ vcount[CELL_LOG2];
    scr_on = (h_i >= off_i) && (h_i < off_i + SCROLL_W);

    red_d   = ZERO;
    green_d = ZERO;
    blue_d  = ZERO;
    case (mode_sel)
      MODE_BLACK: begin
        red_d   = ZERO;
        green_d = ZERO;
        blue_d  = ZERO;
      end
      MODE_WINDOW: begin
        red_d   = win_on ? FULL : ZERO;
        green_d = win_on ? FULL : ZERO;
        blue_d  = win_on ? FULL : ZERO;
      end
      MODE_BARS: begin
        red_d   = bar_s[2] ? FULL : ZERO;
        green_d = bar_s[1] ? FULL : ZERO;
        blue_d  = bar_s[0] ? FULL : ZERO;
      end
      MODE_CHECKER: begin
        red_d   = chk_on ? FULL : ZERO;
        green_d = chk_on ? FULL : ZERO;
        blue_d  = chk_on ? FULL : ZERO;
      end
      MODE_SCROLL: begin
        red_d   = scr_on ? FULL : ZERO;
        green_d = scr_on ? FULL : ZERO;
        blue_d  = scr_on ? FULL : ZERO;
      end
      default: begin
        red_d   = GREY;
        green_d = GREY;
        blue_d  = GREY;
      end
    endcase

    // Blanking overrides every pattern; this also clips the scroll bar.
    if (!active_raw) begin
      red_d   = ZERO;
      green_d = ZERO;
      blue_d  = ZERO;
    end else begin
      red_d   = red_d;
      green_d = green_d;
      blue_d  = blue_d;
    end
  end

  // Mode, offset and colour output registers.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      mode_q   <= 3'd0;
      offset_q <= '0;
      red_q    <= ZERO;
      green_q  <= ZERO;
      blue_q   <= ZERO;
    end else begin
      mode_q   <= mode_d;
      offset_q <= offset_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
    end
  end

  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen on a reduced raster (40x12 totals)
// so that many frames fit in a short run. Expected values come from the
// pixel index since reset release: x = n % H_TOTAL, y = (n / H_TOTAL) % V_TOTAL,
// frame = n / FRAME, and the pattern rules applied with plain arithmetic.
module tb_vga_pattern_gen;

  localparam int HA = 32, HFP = 2, HS = 4, HBP = 2;
  localparam int VA = 8, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int HWID = $clog2(HT);
  localparam int VWID = $clog2(VT);
  localparam bit HPOL = 1'b1;
  localparam bit VPOL = 1'b0;
  localparam int CL = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0]      mode = 3'd0;
  logic            vga_clk, hsync, vsync, active_video, frame_start;
  logic [HWID-1:0] hcount;
  logic [VWID-1:0] vcount;
  logic [7:0]      red, green, blue;

  int total = 0;
  int bad = 0;
  int pix = 0;
  int fm[0:255];

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(HPOL), .VS_POL(VPOL), .COLOR_W(8), .CELL_LOG2(CL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .vga_clk(vga_clk),
    .hsync(hsync), .vsync(vsync), .active_video(active_video),
    .hcount(hcount), .vcount(vcount), .red(red), .green(green),
    .blue(blue), .frame_start(frame_start)
  );

  // Reference colour of pixel (x,y) in mode m with scroll offset off.
  function automatic logic [23:0] exp_rgb(input int x, input int y, input int m, input int off);
    int bar;
    if (x >= HA || y >= VA) return 24'h000000;
    case (m)
      0: return 24'h000000;
      1: return (x > HA / 8 && x < 7 * HA / 8) ? 24'hFFFFFF : 24'h000000;
      2: begin
        bar = x * 8 / HA;
        return {((bar / 4) % 2 == 1) ? 8'hFF : 8'h00,
                ((bar / 2) % 2 == 1) ? 8'hFF : 8'h00,
                (bar % 2 == 1) ? 8'hFF : 8'h00};
      end
      3: return ((x / (1 << CL) + y / (1 << CL)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      4: return (x >= off && x < off + 16) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h808080;
    endcase
  endfunction

  // One pixel clock; remembers the mode presented at each frame origin.
  task automatic tick();
    if (pix % FRAME == 0) fm[(pix / FRAME) % 256] = int'(mode);
    @(posedge clk);
    pix++;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [2:0] m);
    @(negedge clk);
    rst_n = 1'b0;
    mode = m;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    pix = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mode = 3'd2;
    #1;
    total++;
    if ({hcount, vcount} !== '0) begin bad++; $display("FAIL rst_cnt got=%0h exp=0", {hcount, vcount}); end
    total++;
    if ({red, green, blue} !== 24'h0) begin bad++; $display("FAIL rst_rgb got=%0h exp=0", {red, green, blue}); end
    total++;
    if ({active_video, frame_start} !== 2'b00) begin bad++; $display("FAIL rst_av_fs got=%b exp=00", {active_video, frame_start}); end
    total++;
    if ({hsync, vsync} !== {~HPOL, ~VPOL}) begin bad++; $display("FAIL rst_sync got=%b exp=%b", {hsync, vsync}, {~HPOL, ~VPOL}); end
    total++;
    if (vga_clk !== clk) begin bad++; $display("FAIL vga_clk got=%b exp=%b", vga_clk, clk); end
    repeat (3) @(negedge clk);
    total++;
    if (hcount !== '0) begin bad++; $display("FAIL rst_hold got=%0d exp=0", hcount); end
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    pix = 0;
    total++;
    if ({hcount, vcount, frame_start} !== '0) begin bad++; $display("FAIL rel_origin got=%0h exp=0", {hcount, vcount, frame_start}); end
    tick();
    total++;
    if ({frame_start, hcount} !== {1'b1, HWID'(1)}) begin bad++; $display("FAIL rel_fs got=%0h exp=%0h", {frame_start, hcount}, {1'b1, HWID'(1)}); end
    tick();
    total++;
    if ({frame_start, hcount} !== {1'b0, HWID'(2)}) begin bad++; $display("FAIL rel_fs_end got=%0h exp=%0h", {frame_start, hcount}, {1'b0, HWID'(2)}); end
  endtask

  task automatic test_timing();
    int hs_line, vs_tot, fs_cnt, fs_pos, av_tot, nz;
    hs_line = 0; vs_tot = 0; fs_cnt = 0; fs_pos = -1; av_tot = 0; nz = 0;
    mode = 3'd0;
    tick();
    while (pix % FRAME != 1) tick();
    for (int i = 0; i < FRAME; i++) begin
      if (hsync === HPOL) hs_line++;
      if (vsync === VPOL) vs_tot++;
      if (active_video === 1'b1) av_tot++;
      if ({red, green, blue} !== 24'h0) nz++;
      if (frame_start === 1'b1) begin fs_cnt++; fs_pos = i; end
      if (i % HT == HT - 1) begin
        total++;
        if (hs_line != HS) begin bad++; $display("FAIL hs_width line=%0d got=%0d exp=%0d", i / HT, hs_line, HS); end
        hs_line = 0;
      end
      tick();
    end
    total++;
    if (vs_tot != VS * HT) begin bad++; $display("FAIL vs_width got=%0d exp=%0d", vs_tot, VS * HT); end
    total++;
    if (fs_cnt != 1 || fs_pos != 0) begin bad++; $display("FAIL fs_period got=%0d@%0d exp=1@0", fs_cnt, fs_pos); end
    total++;
    if (av_tot != HA * VA) begin bad++; $display("FAIL av_count got=%0d exp=%0d", av_tot, HA * VA); end
    total++;
    if (nz != 0) begin bad++; $display("FAIL black_rgb got=%0d exp=0", nz); end
  endtask

  task automatic test_patterns();
    int m0, chg, p, x, y, f;
    logic [23:0] e_rgb;
    logic e_hs, e_vs;
    m0 = int'($urandom_range(0, 7));
    do_reset(3'(m0));
    for (int k = 0; k < 8; k++) begin
      chg = int'($urandom_range(1, FRAME - 1));
      for (int i = 0; i < FRAME; i++) begin
        if (i == 0) mode = 3'((m0 + k) % 8);
        else if (i == chg) mode = 3'($urandom_range(0, 7));
        tick();
        p = pix - 1; x = p % HT; y = (p / HT) % VT; f = p / FRAME;
        e_rgb = exp_rgb(x, y, fm[f % 256], f % HA);
        e_hs = (x >= HA + HFP && x < HA + HFP + HS) ? HPOL : ~HPOL;
        e_vs = (y >= VA + VFP && y < VA + VFP + VS) ? VPOL : ~VPOL;
        total++;
        if ({hcount, vcount} !== {HWID'(pix % HT), VWID'((pix / HT) % VT)}) begin
          bad++; $display("FAIL pos p=%0d got=%0d,%0d exp=%0d,%0d", pix, hcount, vcount, pix % HT, (pix / HT) % VT);
        end
        total++;
        if ({hsync, vsync} !== {e_hs, e_vs}) begin
          bad++; $display("FAIL sync p=%0d got=%b exp=%b", p, {hsync, vsync}, {e_hs, e_vs});
        end
        total++;
        if ({active_video, frame_start} !== {x < HA && y < VA, x == 0 && y == 0}) begin
          bad++; $display("FAIL av_fs p=%0d got=%b exp=%b", p, {active_video, frame_start}, {x < HA && y < VA, x == 0 && y == 0});
        end
        total++;
        if ({red, green, blue} !== e_rgb) begin
          bad++; $display("FAIL rgb p=%0d mode=%0d got=%06h exp=%06h", p, fm[f % 256], {red, green, blue}, e_rgb);
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    int x, y;
    logic [23:0] e_rgb;
    mode = 3'd1;
    tick();
    while (pix % FRAME != 0) tick();
    for (int j = 0; j < 2 * FRAME; j++) begin
      if (j == 4 * HT + 7) mode = 3'd3;
      tick();
      x = j % HT; y = (j / HT) % VT;
      e_rgb = exp_rgb(x, y, (j < FRAME) ? 1 : 3, 0);
      total++;
      if ({red, green, blue} !== e_rgb) begin
        bad++; $display("FAIL mode_switch j=%0d got=%06h exp=%06h", j, {red, green, blue}, e_rgb);
      end
    end
  endtask

  task automatic test_scroll();
    int first, cnt, off, w;
    do_reset(3'd4);
    for (int f = 0; f <= HA; f++) begin
      first = -1; cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
        tick();
        if (i < HT && {red, green, blue} === 24'hFFFFFF) begin
          if (first < 0) first = i;
          cnt++;
        end
      end
      off = f % HA;
      w = (HA - off < 16) ? HA - off : 16;
      total++;
      if (first != off) begin bad++; $display("FAIL scroll_pos frame=%0d got=%0d exp=%0d", f, first, off); end
      total++;
      if (cnt != w) begin bad++; $display("FAIL scroll_width frame=%0d got=%0d exp=%0d", f, cnt, w); end
    end
  endtask

  task automatic test_reset_midline();
    int first, cnt;
    repeat (HT + 10) tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({hcount, vcount} !== '0) begin bad++; $display("FAIL mid_rst_cnt got=%0h exp=0", {hcount, vcount}); end
    total++;
    if ({red, green, blue, active_video, frame_start} !== '0) begin
      bad++; $display("FAIL mid_rst_out got=%0h exp=0", {red, green, blue, active_video, frame_start});
    end
    total++;
    if ({hsync, vsync} !== {~HPOL, ~VPOL}) begin bad++; $display("FAIL mid_rst_sync got=%b exp=%b", {hsync, vsync}, {~HPOL, ~VPOL}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    pix = 0;
    first = -1; cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (i < HT && {red, green, blue} === 24'hFFFFFF) begin
        if (first < 0) first = i;
        cnt++;
      end
    end
    total++;
    if (first != 0 || cnt != 16) begin bad++; $display("FAIL offset_cleared got=%0d/%0d exp=0/16", first, cnt); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_patterns();
    test_mode_switch();
    test_scroll();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
